aes128_encrypt: RTL and testbench

- Iterative AES-128 block encryptor. It is the forward-direction counterpart of the existing AES-128 decryptor in the HEA crypto datapath.
- Accepts a 128-bit key and a plaintext block on a start pulse and returns the FIPS-197 ciphertext after a fixed 10-cycle latency.
- Computes one full round per clock and expands the round key on the fly, with no round-key table. This keeps area low and makes ciphertext available early for the encrypt/decrypt round-trip flow.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_enc_round.sv | 53 +++++
 rtl/aes128_encrypt.sv | 121 ++++++++++++
 tb/tb_aes128_encrypt.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the HEA crypto datapath.
// Contents:
//   NR, NK       - round count and key length in words for AES-128
//   aes_state_t  - control states of the iterative encryptor
//   SBOX         - forward S-box, indexed by the input byte
//   RCON         - round constants; entry r-1 is used in round r
//   xtime        - multiply by x in GF(2^8), polynomial 0x11b
//   rot_word     - cyclic left rotation of a word by one byte
//   sub_word     - S-box applied to each byte of a word
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic {
        IDLE_S,
        ROUND_S
    } aes_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round, purely combinational.
// Ports:
//   s_i         - round input state, byte n at bits [127-8n -: 8], column-major
//   rk_i        - round key added at the end of the round
//   bypass_mc_i - skip MixColumns (final round)
//   s_o         - SubBytes -> ShiftRows -> optional MixColumns -> AddRoundKey
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] s_i,
    input  logic [127:0] rk_i,
    input  logic         bypass_mc_i,
    output logic [127:0] s_o
);

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [127:0] sr_flat;
    logic [127:0] mc_flat;

    // SubBytes then ShiftRows. Byte 4c+r sits in row r, column c; row r
    // rotates left by r, so it takes the byte from column (c+r) mod 4.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign sb[gi] = SBOX[s_i[127-8*gi -: 8]];
            assign sr[gi] = sb[SRC];
            assign sr_flat[127-8*gi -: 8] = sr[gi];
        end
    endgenerate

    // MixColumns: each column is multiplied by the circulant {02,03,01,01}.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr[4*gi];
            assign a1 = sr[4*gi+1];
            assign a2 = sr[4*gi+2];
            assign a3 = sr[4*gi+3];
            assign mc_flat[127-32*gi -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
    endgenerate

    assign s_o = (bypass_mc_i ? sr_flat : mc_flat) ^ rk_i;

endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryptor: one full round per clock, round keys
// expanded on the fly from the previous round key.
// Ports:
//   clk           - system clock, rising edge
//   rst_n         - asynchronous active-low reset
//   start_i       - begin encryption; sampled only while ready_o=1
//   key_i         - cipher key, bits [127:120] = byte 0
//   plain_text_i  - plaintext block, bits [127:120] = state byte 0
//   cipher_text_o - ciphertext, held until the next completion
//   ready_o       - idle, can accept start_i
//   done_o        - one-cycle pulse when cipher_text_o is updated
module aes128_encrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] plain_text_i,
    output logic [127:0] cipher_text_o,
    output logic         ready_o,
    output logic         done_o
);

    aes_state_t   fsm_reg,   fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] rk_reg,    rk_next;
    logic [3:0]   round_reg, round_next;
    logic [127:0] ct_reg,    ct_next;
    logic         done_reg,  done_next;

    logic [3:0]   rcon_idx;
    logic [7:0]   rcon_byte;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] nk;
    logic [127:0] round_res;
    logic         last_round;

    // Round counter is 0 only while idle, where nk is unused; clamp the
    // index so it stays inside the table.
    assign rcon_idx  = (round_reg == 4'd0) ? 4'd0 : round_reg - 4'd1;
    assign rcon_byte = RCON[rcon_idx];

    // Next round key from the current one.
    assign w0  = rk_reg[127:96];
    assign w1  = rk_reg[95:64];
    assign w2  = rk_reg[63:32];
    assign w3  = rk_reg[31:0];
    assign nw0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon_byte, 24'h000000};
    assign nw1 = w1 ^ nw0;
    assign nw2 = w2 ^ nw1;
    assign nw3 = w3 ^ nw2;
    assign nk  = {nw0, nw1, nw2, nw3};

    assign last_round = (round_reg == 4'(NR));

    aes_enc_round u_round (
        .s_i         (state_reg),
        .rk_i        (nk),
        .bypass_mc_i (last_round),
        .s_o         (round_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg   <= IDLE_S;
            state_reg <= '0;
            rk_reg    <= '0;
            round_reg <= '0;
            ct_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            rk_reg    <= rk_next;
            round_reg <= round_next;
            ct_reg    <= ct_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        rk_next    = rk_reg;
        round_next = round_reg;
        ct_next    = ct_reg;
        done_next  = 1'b0;
        case (fsm_reg)
            IDLE_S: begin
                if (start_i) begin
                    // Initial AddRoundKey happens at capture, so round 1
                    // starts straight from SubBytes.
                    state_next = plain_text_i ^ key_i;
                    rk_next    = key_i;
                    round_next = 4'd1;
                    fsm_next   = ROUND_S;
                end
            end
            ROUND_S: begin
                if (last_round) begin
                    ct_next    = round_res;
                    done_next  = 1'b1;
                    round_next = 4'd0;
                    fsm_next   = IDLE_S;
                end else begin
                    state_next = round_res;
                    rk_next    = nk;
                    round_next = round_reg + 4'd1;
                end
            end
            default: fsm_next = IDLE_S;
        endcase
    end

    assign cipher_text_o = ct_reg;
    assign done_o        = done_reg;
    assign ready_o       = (fsm_reg == IDLE_S);

endmodule

// File: tb/tb_aes128_encrypt.sv
// Self-checking bench for aes128_encrypt. Holds a byte-level AES model
// (S-box derived from GF(2^8) inversion plus the affine map, full key
// schedule, forward and inverse cipher) and a cycle-level timing model.
module tb_aes128_encrypt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic [127:0] plain_text_i = '0;
    logic [127:0] cipher_text_o;
    logic         ready_o;
    logic         done_o;

    always #5 clk = ~clk;

    aes128_encrypt dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .key_i         (key_i),
        .plain_text_i  (plain_text_i),
        .cipher_text_o (cipher_text_o),
        .ready_o       (ready_o),
        .done_o        (done_o)
    );

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    logic chk_en = 1'b0;

    logic [7:0] m_sbox  [256];
    logic [7:0] m_isbox [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- functional model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d = {b, b};
        return d[15-k -: 8];
    endfunction

    function automatic logic [1407:0] key_sched(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] ks = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [7:0] rk_byte(input logic [1407:0] ks, input int r, input int n);
        return ks[1407 - 128*r - 8*n -: 8];
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [1407:0] ks = key_sched(key);
        logic [7:0]    st [16];
        logic [7:0]    t  [16];
        logic [7:0]    a0, a1, a2, a3;
        logic [127:0]  res;
        for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8] ^ rk_byte(ks, 0, n);
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) t[n] = m_sbox[st[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    st[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    st[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            end
            for (int n = 0; n < 16; n++) st[n] = st[n] ^ rk_byte(ks, r, n);
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
        return res;
    endfunction

    // Stand-in for the downstream decryptor: textbook inverse cipher.
    function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [1407:0] ks = key_sched(key);
        logic [7:0]    st [16];
        logic [7:0]    t  [16];
        logic [7:0]    a0, a1, a2, a3;
        logic [127:0]  res;
        for (int n = 0; n < 16; n++) st[n] = ct[127-8*n -: 8] ^ rk_byte(ks, 10, n);
        for (int r = 9; r >= 0; r--) begin
            for (int n = 0; n < 16; n++) t[n] = st[n];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    st[4*((c+row)%4)+row] = t[4*c+row];
            for (int n = 0; n < 16; n++) st[n] = m_isbox[st[n]] ^ rk_byte(ks, r, n);
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
                    st[4*c+1] = gmul(a0, 9)  ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
                    st[4*c+2] = gmul(a0, 13) ^ gmul(a1, 9)  ^ gmul(a2, 14) ^ gmul(a3, 11);
                    st[4*c+3] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9)  ^ gmul(a3, 14);
                end
            end
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
        return res;
    endfunction

    // ---------------- timing model ----------------
    int           m_cnt  = 0;
    logic [127:0] m_ct   = '0;
    logic [127:0] m_pend = '0;
    logic         m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_ct   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_ct   <= m_pend;
                m_done <= 1'b1;
            end
            if (m_cnt == 0 && start_i) begin
                m_pend <= aes_enc(key_i, plain_text_i);
                m_cnt  <= 10;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_done",  {127'd0, done_o},  {127'd0, m_done});
            check("cyc_ready", {127'd0, ready_o}, {127'd0, (m_cnt == 0)});
            check("cyc_ct",    cipher_text_o,     m_ct);
            if (done_o === 1'b1) n_done++;
        end
    end

    // Starts a block at the current negedge, optionally pulses start_i
    // again at cycle pulse_at, and waits up to 20 cycles for done_o.
    task automatic run_block(input logic [127:0] k, input logic [127:0] p, input int pulse_at,
                             output int cyc, output logic [127:0] ct);
        key_i = k;
        plain_text_i = p;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        ct  = '0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == pulse_at) begin
                start_i = 1'b1;
                key_i = {$urandom, $urandom, $urandom, $urandom};
                plain_text_i = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start_i = 1'b0;
            end
            if (done_o === 1'b1) begin
                ct = cipher_text_o;
                break;
            end
        end
        start_i = 1'b0;
        $display("txn key=%h pt=%h ct=%h latency=%0d", k, p, ct, cyc);
    endtask

    int           cyc;
    int           nd0;
    logic [127:0] ct;
    logic [127:0] rk, rp;

    initial begin
        // Model S-box: multiplicative inverse followed by the affine map.
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            m_sbox[a]  = s;
            m_isbox[s] = 8'(a);
        end

        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_ct",    cipher_text_o,      128'd0);
        check("reset_ready", {127'd0, ready_o},  128'd1);
        check("reset_done",  {127'd0, done_o},   128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pin the model to published values.
        check("model_sbox_53", {120'd0, m_sbox[8'h53]}, 128'h00ed);
        check("model_appB",    aes_enc(KB, PB), CB);
        check("model_appC1",   aes_enc(KC, PC), CC);
        check("model_inv_B",   aes_dec(KB, CB), PB);

        // FIPS-197 Appendix B
        @(negedge clk);
        run_block(KB, PB, 0, cyc, ct);
        check("appB_latency", 128'(cyc), 128'd10);
        check("appB_ct",      ct, CB);

        // FIPS-197 Appendix C.1, then input changes without start
        run_block(KC, PC, 0, cyc, ct);
        check("appC1_latency", 128'(cyc), 128'd10);
        check("appC1_ct",      ct, CC);
        key_i = KB;
        plain_text_i = PB;
        repeat (5) @(negedge clk);
        check("hold_ct", cipher_text_o, CC);

        // Back-to-back with start in the done cycle, and an ignored mid-op start
        nd0 = n_done;
        run_block(KB, PB, 0, cyc, ct);
        check("b2b_first_ct", ct, CB);
        run_block(KC, PC, 4, cyc, ct);
        check("b2b_second_latency", 128'(cyc), 128'd10);
        check("b2b_second_ct",      ct, CC);
        repeat (15) @(negedge clk);
        check("b2b_done_count", 128'(n_done - nd0), 128'd2);

        // Reset in the middle of an operation
        key_i = KB;
        plain_text_i = PB;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ct",    cipher_text_o,     128'd0);
        check("midrst_ready", {127'd0, ready_o}, 128'd1);
        check("midrst_done",  {127'd0, done_o},  128'd0);
        nd0 = n_done;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_done", 128'(n_done - nd0), 128'd0);
        run_block(KB, PB, 0, cyc, ct);
        check("after_rst_latency", 128'(cyc), 128'd10);
        check("after_rst_ct",      ct, CB);

        // Round trip through the inverse cipher
        for (int i = 0; i < 100; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            run_block(rk, rp, 0, cyc, ct);
            check("rt_latency", 128'(cyc), 128'd10);
            check("rt_plain",   aes_dec(rk, ct), rp);
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
